// File: rtl/const_scale_pipe.sv
// const_scale_pipe: four-stage complex scaling by one of four radix-5 butterfly
// constants using shift-and-add terms, with a valid/enable pipeline and output
// saturation.
module const_scale_pipe #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   input  logic [1:0]   sel,
   input  logic [W-1:0] a_re,
   input  logic [W-1:0] a_img,
   output logic         out_valid,
   output logic [W-1:0] a1_re,
   output logic [W-1:0] a1_img,
   output logic         sat
);

   // Two guard bits: the largest magnitude (1.539 * 2^(W-1)) fits with no wrap.
   localparam int unsigned XW = W + 2;

   typedef logic signed [XW-1:0] ext_t;

   function automatic ext_t sext(input logic [W-1:0] x);
      return {{2{x[W-1]}}, x};
   endfunction

   // First pair sum (t0 + t1); every shift is taken from the original sample.
   function automatic ext_t pair_a(input logic [W-1:0] x, input logic [1:0] s);
      ext_t xe;
      ext_t r;
      xe = sext(x);
      r  = '0;
      case (s)
         2'd0:    r = xe + (xe >>> 1);
         2'd1:    r = (xe >>> 1) + (xe >>> 4);
         2'd2:    r = (xe >>> 2) + (xe >>> 3);
         2'd3:    r = -xe - (xe >>> 2);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Second pair sum (t2 + t3); unused terms are zero.
   function automatic ext_t pair_b(input logic [W-1:0] x, input logic [1:0] s);
      ext_t xe;
      ext_t r;
      xe = sext(x);
      r  = '0;
      case (s)
         2'd0:    r = (xe >>> 5) + (xe >>> 7);
         2'd1:    r = -(xe >>> 8);
         2'd2:    r = (xe >>> 8) - (xe >>> 6);
         2'd3:    r = '0;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Clamp to W bits; MSB of the result is the saturation flag.
   function automatic logic [W:0] clip(input ext_t v);
      logic         ovf;
      logic [W-1:0] val;
      ovf = (v[XW-1:W-1] != {3{v[XW-1]}});
      if (!ovf) begin
         val = v[W-1:0];
      end else if (v[XW-1]) begin
         val = {1'b1, {(W-1){1'b0}}};
      end else begin
         val = {1'b0, {(W-1){1'b1}}};
      end
      return {ovf, val};
   endfunction

   logic [W-1:0] s1_re_q, s1_im_q;
   logic [1:0]   s1_sel_q;
   logic         s1_vld_q;

   ext_t         p_re_a_q, p_re_b_q, p_im_a_q, p_im_b_q;
   logic         s2_vld_q;

   ext_t         sum_re_q, sum_im_q;
   logic         s3_vld_q;

   logic [W-1:0] re_clip, im_clip;
   logic         re_ovf, im_ovf;

   // S1: capture sample, coefficient select and valid together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_re_q  <= '0;
         s1_im_q  <= '0;
         s1_sel_q <= '0;
         s1_vld_q <= 1'b0;
      end else if (en) begin
         s1_re_q  <= a_re;
         s1_im_q  <= a_img;
         s1_sel_q <= sel;
         s1_vld_q <= in_valid;
      end
   end

   // S2: form the four terms and add them pairwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_re_a_q <= '0;
         p_re_b_q <= '0;
         p_im_a_q <= '0;
         p_im_b_q <= '0;
         s2_vld_q <= 1'b0;
      end else if (en) begin
         p_re_a_q <= pair_a(s1_re_q, s1_sel_q);
         p_re_b_q <= pair_b(s1_re_q, s1_sel_q);
         p_im_a_q <= pair_a(s1_im_q, s1_sel_q);
         p_im_b_q <= pair_b(s1_im_q, s1_sel_q);
         s2_vld_q <= s1_vld_q;
      end
   end

   // S3: combine the pair sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_re_q <= '0;
         sum_im_q <= '0;
         s3_vld_q <= 1'b0;
      end else if (en) begin
         sum_re_q <= p_re_a_q + p_re_b_q;
         sum_im_q <= p_im_a_q + p_im_b_q;
         s3_vld_q <= s2_vld_q;
      end
   end

   // Saturate both components of the S3 sum.
   always_comb begin
      {re_ovf, re_clip} = clip(sum_re_q);
      {im_ovf, im_clip} = clip(sum_im_q);
   end

   // S4: register saturated outputs, flag and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_re     <= '0;
         a1_img    <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
      end else if (en) begin
         a1_re     <= re_clip;
         a1_img    <= im_clip;
         sat       <= re_ovf | im_ovf;
         out_valid <= s3_vld_q;
      end
   end

endmodule
